// File: rtl/spi_wb_master.sv
// rtl/spi_wb_master.sv - SPI byte-stream command parser bridging to a classic Wishbone master.
module spi_wb_master #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_rx_valid,
    input  logic [7:0]               spi_rx_data,
    output logic                     spi_tx_valid,
    output logic [7:0]               spi_tx_data,
    input  logic                     spi_tx_ready,
    input  logic                     spi_cs_n,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic                     wb_we_o,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, LEN, ADDR, RD_DATA, WR_DATA, TERM} state_t;

    state_t                   state, state_next;
    logic [15:0]              cnt;
    logic [15:0]              len;
    logic [31:0]              addr;
    logic [WB_DATA_WIDTH-1:0] rd_word;
    logic [WB_DATA_WIDTH-1:0] wr_word;
    logic [WB_DATA_WIDTH-1:0] wr_next;
    logic                     rd_err;
    logic                     wr_err;
    logic                     is_rd;
    logic                     started;
    logic                     rx;
    logic                     wb_done;
    logic                     valid_cmd;
    logic                     last_pl;
    logic [1:0]               idx;
    logic [3:0]               lanes;
    logic [31:0]              full_addr;

    assign rx        = spi_rx_valid && !spi_cs_n;
    assign wb_done   = wb_cyc_o && (wb_ack_i || wb_err_i);
    assign valid_cmd = (spi_rx_data == 8'hA1) || (spi_rx_data == 8'hA2);
    assign last_pl   = (cnt == len - 16'd1);
    assign idx       = cnt[1:0];
    assign lanes     = {idx == 2'd3, idx >= 2'd2, idx >= 2'd1, 1'b1};
    assign full_addr = {spi_rx_data, addr[23:0]};
    assign wb_stb_o  = wb_cyc_o;
    assign busy      = (state != IDLE);

    always_comb begin
        wr_next = wr_word;
        wr_next[{idx, 3'b000} +: 8] = spi_rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Chip-select abort waits for an in-flight bus cycle before leaving the frame.
    always_comb begin
        state_next = state;
        if (spi_cs_n && state != IDLE) begin
            if (!wb_cyc_o || wb_done) state_next = IDLE;
        end else if (rx) begin
            case (state)
                IDLE:    if (valid_cmd) state_next = LEN;
                LEN:     if (cnt == 16'd1) state_next = ADDR;
                ADDR:    if (cnt == 16'd3) state_next = (len == 16'd0) ? TERM : (is_rd ? RD_DATA : WR_DATA);
                RD_DATA: if (last_pl) state_next = TERM;
                WR_DATA: if (last_pl) state_next = TERM;
                TERM:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started      <= 1'b0;
            spi_tx_valid <= 1'b0;
            spi_tx_data  <= 8'hDA;
            wb_cyc_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= 4'h0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            cnt          <= 16'd0;
            len          <= 16'd0;
            addr         <= 32'd0;
            rd_word      <= '0;
            wr_word      <= '0;
            rd_err       <= 1'b0;
            wr_err       <= 1'b0;
            is_rd        <= 1'b0;
        end else begin
            started <= 1'b1;
            if (!started) spi_tx_valid <= 1'b1;
            else if (spi_tx_valid && spi_tx_ready) spi_tx_valid <= 1'b0;

            if (wb_done) begin
                wb_cyc_o <= 1'b0;
                if (wb_we_o) begin
                    wr_err <= wr_err | wb_err_i;
                end else begin
                    rd_word <= wb_dat_i;
                    rd_err  <= wb_err_i;
                end
            end

            if (state_next != state) cnt <= 16'd0;
            else if (rx)             cnt <= cnt + 16'd1;

            if (spi_cs_n && state != IDLE && state_next == IDLE) begin
                spi_tx_data  <= 8'hDA;
                spi_tx_valid <= 1'b1;
            end

            if (rx) begin
                spi_tx_valid <= 1'b1;
                case (state)
                    IDLE: begin
                        spi_tx_data <= valid_cmd ? (spi_rx_data & 8'h7F) : 8'hDA;
                        is_rd       <= (spi_rx_data == 8'hA1);
                        wr_err      <= 1'b0;
                        wr_word     <= '0;
                    end
                    LEN: begin
                        spi_tx_data <= 8'h00;
                        len[{cnt[0], 3'b000} +: 8] <= spi_rx_data;
                    end
                    ADDR: begin
                        spi_tx_data <= 8'h00;
                        addr[{cnt[1:0], 3'b000} +: 8] <= spi_rx_data;
                        if (cnt == 16'd3 && is_rd && len != 16'd0) begin
                            wb_cyc_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= WB_ADDR_WIDTH'(full_addr);
                        end
                    end
                    RD_DATA: begin
                        spi_tx_data <= rd_err ? 8'h00 : rd_word[{idx, 3'b000} +: 8];
                        // Next word is fetched as soon as the current one is fully consumed.
                        if (idx == 2'd3 && !last_pl) begin
                            addr     <= addr + 32'd4;
                            wb_cyc_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= WB_ADDR_WIDTH'(addr + 32'd4);
                        end
                    end
                    WR_DATA: begin
                        spi_tx_data <= wr_err ? 8'hEF : 8'hEE;
                        if (idx == 2'd3 || last_pl) begin
                            addr     <= addr + 32'd4;
                            wb_cyc_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= lanes;
                            wb_adr_o <= WB_ADDR_WIDTH'(addr);
                            wb_dat_o <= wr_next;
                            wr_word  <= '0;
                        end else begin
                            wr_word <= wr_next;
                        end
                    end
                    TERM:    spi_tx_data <= 8'hDA;
                    default: spi_tx_data <= 8'hDA;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_wb_master.sv
// tb/tb_spi_wb_master.sv - randomized frame bench for spi_wb_master against a frame-level model.
module tb_spi_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_rx_valid = 1'b0;
    logic [7:0]  spi_rx_data = 8'h00;
    logic        spi_tx_valid;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_ready = 1'b0;
    logic        spi_cs_n = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    spi_wb_master #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
        .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
        .spi_cs_n(spi_cs_n),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wb_t         wb_log[$];
    wb_t         wb_exp[$];
    logic [7:0]  frm[$];
    logic [7:0]  miso[$];
    logic [7:0]  exp_miso[$];
    bit          err_addr[int unsigned];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD0040;
        if (a == 32'h104) return 32'hDEAD0041;
        return (a * 32'h9E37) ^ 32'h5A5A1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wishbone slave: random latency, error on listed addresses.
    initial begin
        forever begin : serve
            wb_t t;
            int  lat;
            @(posedge clk);
            #2;
            if (wb_cyc_o && wb_stb_o) begin
                t.we  = wb_we_o;
                t.adr = wb_adr_o;
                t.dat = wb_we_o ? wb_dat_o : 32'h0;
                t.sel = wb_sel_o;
                wb_log.push_back(t);
                lat = $urandom_range(2, 12);
                repeat (lat) begin
                    @(posedge clk);
                    #2;
                end
                if (rst) begin
                    check("wb_hold_cyc", {31'd0, wb_cyc_o}, 32'd1);
                    check("wb_hold_adr", wb_adr_o, t.adr);
                end
                wb_dat_i = mem_rd(t.adr);
                if (err_addr.exists(t.adr)) wb_err_i = 1'b1;
                else                        wb_ack_i = 1'b1;
                @(posedge clk);
                #2;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end
    end

    task automatic xfer(input logic [7:0] mosi, output logic [7:0] got, input int gap);
        check("tx_valid_pending", {31'd0, spi_tx_valid}, 32'd1);
        got = spi_tx_data;
        spi_tx_ready = 1'b1;
        tick();
        spi_tx_ready = 1'b0;
        spi_rx_data  = mosi;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic build_expect();
        logic [7:0]  cmd;
        logic [31:0] base, wa, d;
        int          len, n;
        bit          errored;
        exp_miso.delete();
        wb_exp.delete();
        exp_miso.push_back(8'hDA);
        cmd = frm[0];
        if (cmd != 8'hA1 && cmd != 8'hA2) begin
            for (int k = 1; k < frm.size(); k++) exp_miso.push_back(8'hDA);
            return;
        end
        exp_miso.push_back(cmd & 8'h7F);
        for (int k = 0; k < 6; k++) exp_miso.push_back(8'h00);
        len     = int'(frm[1]) + 256 * int'(frm[2]);
        base    = {frm[6], frm[5], frm[4], frm[3]};
        errored = 0;
        for (int w = 0; w * 4 < len; w++) begin
            wb_t e;
            wa = base + 32'(4 * w);
            n  = (len - 4 * w) < 4 ? (len - 4 * w) : 4;
            if (cmd == 8'hA1) begin
                d = mem_rd(wa);
                for (int b = 0; b < n; b++)
                    exp_miso.push_back(err_addr.exists(wa) ? 8'h00 : 8'((d >> (8 * b)) & 32'hFF));
                e.we = 1'b0; e.adr = wa; e.dat = 32'h0; e.sel = 4'hF;
            end else begin
                d = 32'h0;
                for (int b = 0; b < n; b++) begin
                    d = d | (32'(frm[7 + 4 * w + b]) << (8 * b));
                    exp_miso.push_back(errored ? 8'hEF : 8'hEE);
                end
                e.we = 1'b1; e.adr = wa; e.dat = d; e.sel = 4'((1 << n) - 1);
                if (err_addr.exists(wa)) errored = 1;
            end
            wb_exp.push_back(e);
        end
    endtask

    task automatic run_frame(input string tag);
        logic [7:0]  b;
        logic [31:0] mask;
        bit          valid;
        build_expect();
        wb_log.delete();
        miso.delete();
        valid = (frm[0] == 8'hA1 || frm[0] == 8'hA2);
        for (int k = 0; k < frm.size(); k++) begin
            xfer(frm[k], b, 40);
            miso.push_back(b);
            check($sformatf("%s_busy%0d", tag, k), {31'd0, busy},
                  (valid && k < frm.size() - 1) ? 32'd1 : 32'd0);
        end
        check($sformatf("%s_miso_len", tag), miso.size(), exp_miso.size());
        for (int k = 0; k < miso.size() && k < exp_miso.size(); k++)
            check($sformatf("%s_miso%0d", tag, k), miso[k], exp_miso[k]);
        check($sformatf("%s_wb_count", tag), wb_log.size(), wb_exp.size());
        for (int k = 0; k < wb_log.size() && k < wb_exp.size(); k++) begin
            check($sformatf("%s_wb%0d_we", tag, k), {31'd0, wb_log[k].we}, {31'd0, wb_exp[k].we});
            check($sformatf("%s_wb%0d_adr", tag, k), wb_log[k].adr, wb_exp[k].adr);
            if (wb_exp[k].we) begin
                mask = {{8{wb_exp[k].sel[3]}}, {8{wb_exp[k].sel[2]}}, {8{wb_exp[k].sel[1]}}, {8{wb_exp[k].sel[0]}}};
                check($sformatf("%s_wb%0d_sel", tag, k), {28'd0, wb_log[k].sel}, {28'd0, wb_exp[k].sel});
                check($sformatf("%s_wb%0d_dat", tag, k), wb_log[k].dat & mask, wb_exp[k].dat);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        check({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        check({tag, "_we"}, {31'd0, wb_we_o}, 32'd0);
        check({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
        check({tag, "_adr"}, wb_adr_o, 32'd0);
        check({tag, "_dat"}, wb_dat_o, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_valid"}, {31'd0, spi_tx_valid}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, spi_tx_data}, 32'hDA);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [31:0] a, input int len);
        logic [7:0] b;
        xfer(cmd, b, 40);
        xfer(8'(len), b, 40);
        xfer(8'(len >> 8), b, 40);
        xfer(a[7:0], b, 40);
        xfer(a[15:8], b, 40);
        xfer(a[23:16], b, 40);
        xfer(a[31:24], b, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          len;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) tick();
        check("post_reset_tx_valid", {31'd0, spi_tx_valid}, 32'd1);
        check("post_reset_tx_data", {24'd0, spi_tx_data}, 32'hDA);

        err_addr[32'h300] = 1;
        err_addr[32'h400] = 1;
        for (int k = 0; k < 12; k++) err_addr[32'h1000 + 32'(4 * $urandom_range(0, 63))] = 1;

        frm = '{8'hA1, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 8'hDA};
        run_frame("read4");
        frm = '{8'hA2, 8'h04, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hDA};
        run_frame("write4");
        frm = '{8'hA1, 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDA};
        run_frame("burst8");
        frm = '{8'hBB, 8'h00, 8'h00};
        run_frame("invalid");
        frm = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'hDA};
        run_frame("len0");
        frm = '{8'hA2, 8'h06, 8'h00, 8'h10, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hDA};
        run_frame("write6");
        frm = '{8'hA1, 8'h06, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'hDA};
        run_frame("read_err");
        frm = '{8'hA2, 8'h07, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'hDA};
        run_frame("write_err");

        // Abort a write frame right after its address.
        wb_log.delete();
        send_header(8'hA2, 32'h200, 4);
        repeat (40) tick();
        spi_cs_n = 1'b1;
        repeat (4) tick();
        check("abort_wr_busy", {31'd0, busy}, 32'd0);
        check("abort_wr_tx", {24'd0, spi_tx_data}, 32'hDA);
        check("abort_wr_no_wb", wb_log.size(), 32'd0);
        spi_cs_n = 1'b0;
        tick();
        frm = '{8'hA2, 8'h04, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hDA};
        run_frame("after_abort");

        // Abort a read while its bus cycle is still open.
        send_header(8'hA1, 32'h100, 4);
        spi_cs_n = 1'b1;
        tick();
        check("abort_rd_busy_held", {31'd0, busy}, 32'd1);
        check("abort_rd_cyc_held", {31'd0, wb_cyc_o}, 32'd1);
        repeat (20) tick();
        check("abort_rd_busy", {31'd0, busy}, 32'd0);
        check("abort_rd_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("abort_rd_tx", {24'd0, spi_tx_data}, 32'hDA);
        check("abort_rd_tx_valid", {31'd0, spi_tx_valid}, 32'd1);
        spi_cs_n = 1'b0;
        tick();

        for (int it = 0; it < 18; it++) begin
            len = $urandom_range(0, 10);
            a   = 32'h1000 + 32'(4 * $urandom_range(0, 48));
            frm.delete();
            frm.push_back($urandom_range(0, 1) ? 8'hA1 : 8'hA2);
            frm.push_back(8'(len));
            frm.push_back(8'h00);
            for (int k = 0; k < 4; k++) frm.push_back(a[8 * k +: 8]);
            for (int k = 0; k < len; k++) frm.push_back(8'($urandom_range(0, 255)));
            frm.push_back(8'hDA);
            run_frame($sformatf("rand%0d", it));
        end

        // Asynchronous reset in the middle of a read cycle.
        send_header(8'hA1, 32'h100, 4);
        check("mid_rst_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b1;
        repeat (20) tick();
        check("mid_rst_tx_valid", {31'd0, spi_tx_valid}, 32'd1);
        check("mid_rst_tx_data", {24'd0, spi_tx_data}, 32'hDA);
        frm = '{8'hA1, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 8'hDA};
        run_frame("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
